// File: rtl/huffman_pair_sequencer_pkg.sv
// huff_pkg: shared sizes, EOB constants and FSM state type for the Huffman pair sequencer.
// No ports; imported by the interface, the LUT and the sequencer top.
package huff_pkg;
    localparam int MAX_PAIRS = 64;
    localparam int ADDR_W    = 6;
    localparam int VAL_W     = 8;
    localparam int CODE_W    = 16;
    localparam int CNT_W     = 7;
    localparam logic [VAL_W-1:0] EOB_VALUE = '0;
    localparam logic [VAL_W-1:0] EOB_COUNT = '0;
    typedef enum logic [2:0] {IDLE, READ, LOOKUP, EMIT, FINISH} state_t;
endpackage

// File: rtl/huffman_pair_sequencer_if.sv
// huffman_pair_sequencer_if: pair-memory read port plus the code valid/ready stream.
// master = sequencer side (drives rd_en/rd_addr/code_out/code_valid),
// slave  = memory + packer side (drives rd_value/rd_count/code_ready).
interface huffman_pair_sequencer_if;
    import huff_pkg::*;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [VAL_W-1:0]  rd_value;
    logic [VAL_W-1:0]  rd_count;
    logic [CODE_W-1:0] code_out;
    logic              code_valid;
    logic              code_ready;
    modport master (
        output rd_en, rd_addr, code_out, code_valid,
        input  rd_value, rd_count, code_ready
    );
    modport slave (
        input  rd_en, rd_addr, code_out, code_valid,
        output rd_value, rd_count, code_ready
    );
endinterface

// File: rtl/huffman_pair_sequencer_lut.sv
// huffman_lut: combinational (value, count) -> 16-bit Huffman code table.
// Ports: value, count (VAL_W each) in; huff_code (CODE_W) out.
// The EOB pair maps to the 4-bit code 1010; any other pair packs the
// run/value nibbles into a fixed-length code.
module huffman_lut
    import huff_pkg::*;
(
    input  logic [VAL_W-1:0]  value,
    input  logic [VAL_W-1:0]  count,
    output logic [CODE_W-1:0] huff_code
);
    assign huff_code = (value == EOB_VALUE && count == EOB_COUNT) ? 16'h000A
                     : {count[3:0], value, count[7:4]} ^ 16'h8001;
endmodule

// File: rtl/huffman_pair_sequencer.sv
// huffman_pair_sequencer: walks a block of (value, count) pairs through huffman_lut and streams the codes.
// Ports: clk_in, rst_in (async, active-high); start/num_pairs begin a block, abort cancels it;
// bus (master modport) carries the pair-memory read port and the code valid/ready stream;
// busy is high outside IDLE, done pulses for one cycle at completion, code_count holds codes emitted.
module huffman_pair_sequencer
    import huff_pkg::*;
(
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     start,
    input  logic                     abort,
    input  logic [CNT_W-1:0]         num_pairs,
    huffman_pair_sequencer_if.master bus,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         code_count
);
    state_t            state, state_nx;
    logic [CNT_W-1:0]  n;
    logic [CNT_W-1:0]  n_clamp;
    logic [ADDR_W-1:0] index;
    logic              eob_flag;
    logic              handshake;
    logic              last;
    logic [CODE_W-1:0] lut_code;

    huffman_lut u_lut (
        .value     (bus.rd_value),
        .count     (bus.rd_count),
        .huff_code (lut_code)
    );

    assign n_clamp   = (num_pairs > CNT_W'(MAX_PAIRS)) ? CNT_W'(MAX_PAIRS) : num_pairs;
    assign handshake = bus.code_valid && bus.code_ready;
    // index is only ever compared while n >= 1, so n - 1 cannot underflow here
    assign last      = eob_flag || ({1'b0, index} == n - CNT_W'(1));

    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        if (abort) state_nx = IDLE;
        else case (state)
            IDLE:    if (start) state_nx = (n_clamp == '0) ? FINISH : READ;
            READ:    state_nx = LOOKUP;
            LOOKUP:  state_nx = EMIT;
            EMIT:    if (handshake) state_nx = last ? FINISH : READ;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = state != IDLE;
        done = state == FINISH;
    end

    // rd_en is a one-cycle strobe: cleared every edge unless a fetch is issued
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bus.rd_en      <= 1'b0;
            bus.rd_addr    <= '0;
            bus.code_out   <= '0;
            bus.code_valid <= 1'b0;
            code_count     <= '0;
            n              <= '0;
            index          <= '0;
            eob_flag       <= 1'b0;
        end else begin
            bus.rd_en <= 1'b0;
            if (abort) begin
                bus.code_valid <= 1'b0;
            end else if (state == IDLE && start) begin
                n           <= n_clamp;
                index       <= '0;
                code_count  <= '0;
                bus.rd_en   <= n_clamp != '0;
                bus.rd_addr <= '0;
            end else if (state == LOOKUP) begin
                bus.code_out   <= lut_code;
                bus.code_valid <= 1'b1;
                eob_flag       <= bus.rd_value == EOB_VALUE && bus.rd_count == EOB_COUNT;
            end else if (state == EMIT && handshake) begin
                bus.code_valid <= 1'b0;
                code_count     <= code_count + CNT_W'(1);
                if (!last) begin
                    index       <= index + ADDR_W'(1);
                    bus.rd_en   <= 1'b1;
                    bus.rd_addr <= index + ADDR_W'(1);
                end
            end
        end
    end
endmodule
